alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single registered issue stage: decodes RV32I integer/address ops into ALU
// select and operands, with a valid/ready handshake and a flush input.
module alu_issue (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_flush,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [6:0]  I_opcode,
  input  logic [2:0]  I_funct3,
  input  logic        I_funct7b5,
  input  logic [31:0] I_rs1,
  input  logic [31:0] I_rs2,
  input  logic [31:0] I_imm,
  input  logic [31:0] I_pc,
  input  logic [4:0]  I_rd,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [3:0]  O_ALUSel,
  output logic [31:0] O_op1,
  output logic [31:0] O_op2,
  output logic [4:0]  O_rd,
  output logic        O_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SELW  = 4;
  localparam int unsigned RIDXW = 5;
  localparam int unsigned SHW   = 5;

  localparam logic [SELW-1:0] ALU_ADD  = 4'd0;
  localparam logic [SELW-1:0] ALU_SLL  = 4'd1;
  localparam logic [SELW-1:0] ALU_SLT  = 4'd2;
  localparam logic [SELW-1:0] ALU_SLTU = 4'd3;
  localparam logic [SELW-1:0] ALU_XOR  = 4'd4;
  localparam logic [SELW-1:0] ALU_SRL  = 4'd5;
  localparam logic [SELW-1:0] ALU_OR   = 4'd6;
  localparam logic [SELW-1:0] ALU_AND  = 4'd7;
  localparam logic [SELW-1:0] ALU_SUB  = 4'd12;
  localparam logic [SELW-1:0] ALU_SRA  = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [SELW-1:0] sel;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RIDXW-1:0] rd;
    logic            illegal;
  } issue_t;

  issue_t          dec_c;
  issue_t          ent_q;
  logic            valid_q;
  logic            is_shift_c;
  logic [XLEN-1:0] src2_c;

  // Combinational decode of the offered instruction
  always_comb begin
    dec_c      = '0;
    dec_c.sel  = ALU_ADD;
    dec_c.rd   = I_rd;
    is_shift_c = 1'b0;
    src2_c     = (I_opcode == OPC_OP) ? I_rs2 : I_imm;
    unique case (I_opcode)
      OPC_OP, OPC_OPIMM: begin
        dec_c.op1 = I_rs1;
        dec_c.op2 = src2_c;
        unique case (I_funct3)
          3'b000: dec_c.sel = (I_opcode == OPC_OP && I_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin dec_c.sel = ALU_SLL; is_shift_c = 1'b1; end
          3'b010: dec_c.sel = ALU_SLT;
          3'b011: dec_c.sel = ALU_SLTU;
          3'b100: dec_c.sel = ALU_XOR;
          3'b101: begin dec_c.sel = I_funct7b5 ? ALU_SRA : ALU_SRL; is_shift_c = 1'b1; end
          3'b110: dec_c.sel = ALU_OR;
          default: dec_c.sel = ALU_AND;
        endcase
        // Shift amount is only the low five bits of the source
        if (is_shift_c) dec_c.op2 = {(XLEN-SHW)'(0), src2_c[SHW-1:0]};
      end
      OPC_LUI: begin
        dec_c.op2 = I_imm;
      end
      OPC_AUIPC, OPC_BRANCH: begin
        dec_c.op1 = I_pc;
        dec_c.op2 = I_imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec_c.op1 = I_pc;
        dec_c.op2 = XLEN'(4);
      end
      OPC_LOAD, OPC_STORE: begin
        dec_c.op1 = I_rs1;
        dec_c.op2 = I_imm;
      end
      default: begin
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  assign O_ready = !I_flush && (!valid_q || I_ready);

  // Pipeline register: flush wins, then capture, then drain
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (I_flush) begin
      valid_q <= 1'b0;
    end else if (I_valid && O_ready) begin
      valid_q <= 1'b1;
      ent_q   <= dec_c;
    end else if (I_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign O_valid   = valid_q;
  assign O_ALUSel  = ent_q.sel;
  assign O_op1     = ent_q.op1;
  assign O_op2     = ent_q.op2;
  assign O_rd      = ent_q.rd;
  assign O_illegal = ent_q.illegal;

endmodule
